// File: rtl/mux_reg_8x8_if.sv
// Data/select/scan bundle for the 8x8 register bank.
// The producer side drives data, enables and scan control; the bank returns read data and scan out.
interface mux_reg_8x8_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    logic [WIDTH-1:0] din;
    logic [DEPTH-1:0] en_in;
    logic [DEPTH-1:0] en_out;
    logic [WIDTH-1:0] dout;
    logic             tc;
    logic             td;
    logic             tq;

    modport master (output din, en_in, en_out, tc, td, input dout, tq);
    modport slave  (input din, en_in, en_out, tc, td, output dout, tq);
endinterface

// File: rtl/mux_reg_8x8.sv
// DEPTH x WIDTH register bank: one-hot write enables, OR-combined read select,
// and a single scan chain threaded through every storage bit.
module mux_reg_8x8_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tc,
    input  logic             we,
    input  logic             si,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sh;

    // Scan moves toward the MSB; bit 0 takes the upstream chain bit.
    generate
        if (WIDTH == 1) begin : g_sh1
            assign sh = si;
        end else begin : g_shn
            assign sh = {q[WIDTH-2:0], si};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (tc)
            q <= sh;
        else if (we)
            q <= d;
    end
endmodule

module mux_reg_8x8 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_reg_8x8_if.slave   bus
);
    logic [DEPTH-1:0][WIDTH-1:0] r;
    logic [DEPTH:0]              chain;
    logic [WIDTH-1:0]            rd;

    assign chain[0] = bus.td;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_entry
            mux_reg_8x8_entry #(.WIDTH(WIDTH)) u_entry (
                .clk   (clk),
                .rst_n (rst_n),
                .tc    (bus.tc),
                .we    (bus.en_in[i]),
                .si    (chain[i]),
                .d     (bus.din),
                .q     (r[i])
            );
            assign chain[i+1] = r[i][WIDTH-1];
        end
    endgenerate

    assign bus.tq = chain[DEPTH];

    // AND-OR read: plain mux for one-hot selects, OR of entries otherwise.
    always_comb begin
        rd = '0;
        for (int k = 0; k < DEPTH; k++)
            if (bus.en_out[k]) rd = rd | r[k];
    end

    assign bus.dout = rd;
endmodule

// File: tb/tb_mux_reg_8x8.sv
// Self-checking bench for mux_reg_8x8: directed vector table, scan/reset sequences,
// and randomized traffic against a flat 64-bit reference image.
module tb_mux_reg_8x8;
    localparam int W = 8;
    localparam int D = 8;
    localparam int N = W * D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_reg_8x8_if #(.WIDTH(W), .DEPTH(D)) bus ();
    mux_reg_8x8 #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    // Reference image: bit (i*W + j) is entry i, bit j; scan position order matches bit index.
    logic [N-1:0] img = '0;

    typedef struct {
        logic [7:0] en_in;
        logic [7:0] din;
        logic [7:0] en_out;
        logic [7:0] exp_out;
    } vec_t;
    vec_t vt[$];

    function automatic logic [W-1:0] ref_read(input logic [D-1:0] sel);
        logic [W-1:0] v = '0;
        for (int i = 0; i < D; i++)
            if (sel[i]) v = v | img[i*W +: W];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One rising edge; model follows the same sampled inputs. Leaves time at edge+1.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (bus.tc)
                img = {img[N-2:0], bus.td};
            else
                for (int i = 0; i < D; i++)
                    if (bus.en_in[i]) img[i*W +: W] = bus.din;
        end
        #1;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        img = '0;
        #1;
        for (int i = 0; i < D; i++) begin
            bus.en_out = 8'h01 << i;
            #1 chk("reset_out", bus.dout, 8'h00);
        end
        chk("reset_tq", bus.tq, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < D; i++) begin
            bus.en_out = 8'h01 << i;
            #1 chk(name, bus.dout, ref_read(8'h01 << i));
        end
    endtask

    initial begin
        logic [63:0] pat;
        logic [7:0]  snap;

        bus.din = '0; bus.en_in = '0; bus.en_out = 8'hFF; bus.tc = 1'b0; bus.td = 1'b0;

        // Power-on reset
        #3 chk("por_out", bus.dout, 8'h00);
        chk("por_tq", bus.tq, 1'b0);
        #4 rst_n = 1'b1;

        // Directed table: write with en_in/din on one edge, then read en_out.
        vt.push_back('{8'h08, 8'hA5, 8'h08, 8'hA5});
        vt.push_back('{8'h80, 8'h3C, 8'h80, 8'h3C});
        vt.push_back('{8'h00, 8'hFF, 8'h08, 8'hA5});
        vt.push_back('{8'h00, 8'h00, 8'h01, 8'h00});
        vt.push_back('{8'h03, 8'hF0, 8'h01, 8'hF0});
        vt.push_back('{8'h00, 8'h11, 8'h02, 8'hF0});
        vt.push_back('{8'h04, 8'h0F, 8'h06, 8'hFF});
        vt.push_back('{8'h00, 8'h0F, 8'h00, 8'h00});
        vt.push_back('{8'h00, 8'h00, 8'h84, 8'h3F});
        vt.push_back('{8'h00, 8'h00, 8'h88, 8'hBD});
        for (int k = 0; k < vt.size(); k++) begin
            bus.en_in = vt[k].en_in; bus.din = vt[k].din; bus.en_out = vt[k].en_out;
            step();
            bus.en_in = '0;
            #1 chk($sformatf("vec%0d", k), bus.dout, vt[k].exp_out);
        end

        // Read of an entry being written: old value before the edge, new after.
        bus.en_out = 8'h01; bus.en_in = 8'h01; bus.din = 8'h55;
        #1 chk("rw_old", bus.dout, 8'hF0);
        step();
        bus.en_in = '0;
        #1 chk("rw_new", bus.dout, 8'h55);

        // Hold: en_in idle while din toggles.
        bus.en_out = 8'h08; snap = 8'hA5;
        for (int c = 0; c < 10; c++) begin
            bus.din = 8'($urandom);
            step();
            chk("hold_sel", bus.dout, snap);
        end
        check_all("hold_all");

        // Async reset with no clock edge
        async_reset();

        // Scan in a 64-bit pattern with en_in forced high (must be ignored).
        pat = {$urandom, $urandom};
        for (int i = 0; i < D; i++) begin
            bus.en_in = 8'h01 << i; bus.din = 8'($urandom | 1); step();
        end
        bus.tc = 1'b1; bus.en_in = 8'hFF;
        for (int k = 0; k < N; k++) begin
            bus.td = pat[k]; bus.din = 8'($urandom);
            bus.en_out = 8'($urandom);
            step();
            chk("scan_in_out", bus.dout, ref_read(bus.en_out));
        end
        bus.tc = 1'b0; bus.en_in = '0;
        for (int i = 0; i < D; i++) begin
            logic [7:0] e;
            for (int j = 0; j < W; j++) e[j] = pat[63 - (i*W + j)];
            bus.en_out = 8'h01 << i;
            #1 chk($sformatf("scan_place%0d", i), bus.dout, e);
        end

        // Unload: pattern comes out first bit first.
        bus.tc = 1'b1; bus.td = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("scan_out%0d", k), bus.tq, pat[k]);
            step();
        end
        check_all("scan_drained");

        // Reset mid-scan, then a full 64 edges to carry TD to TQ.
        bus.tc = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.td = 1'b1; step();
        end
        async_reset();
        bus.td = 1'b1; step();
        bus.td = 1'b0;
        for (int k = 1; k < N; k++) begin
            if (bus.tq !== 1'b0) chk("midscan_early", bus.tq, 1'b0);
            step();
        end
        chk("midscan_tq", bus.tq, 1'b1);
        bus.tc = 1'b0;

        // Randomized traffic against the reference image.
        for (int c = 0; c < 400; c++) begin
            bus.tc     = ($urandom_range(0, 3) == 0);
            bus.td     = 1'($urandom);
            bus.din    = 8'($urandom);
            bus.en_in  = ($urandom_range(0, 1) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
            bus.en_out = ($urandom_range(0, 1) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
            step();
            chk("rnd_out", bus.dout, ref_read(bus.en_out));
            chk("rnd_tq", bus.tq, img[N-1]);
            if (c % 97 == 50) async_reset();
        end
        check_all("rnd_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_reg_8x8.md
# mux_reg_8x8

Eight-entry by eight-bit register bank with a one-hot write-enable bus, a one-hot output-select bus and a scan chain through every storage bit. It sits between the data-result bus and a page-select consumer. A result byte is captured into any combination of entries, and the selected entry is presented combinationally on OUT. TC/TD/TQ give test access to all 64 flops.

## Interface
- WIDTH, default 8: bits per entry.
- DEPTH, default 8: number of entries. EN_IN and EN_OUT are DEPTH bits wide.
- CLK, input, 1: sole clock. All flops update on its rising edge.
- RESET_N, input, 1: reset, asynchronous and active-low.
- IN, input, WIDTH: write data.
- EN_IN, input, DEPTH: per-entry write enable. Bit i writes entry i.
- EN_OUT, input, DEPTH: per-entry output select. Bit i selects entry i.
- OUT, output, WIDTH: selected read data.
- TC, input, 1: test control (scan enable). 1 = shift mode.
- TD, input, 1: scan data in.
- TQ, output, 1: scan data out.

## Operation
- Storage: entries R[0..DEPTH-1], each WIDTH bits, DEPTH*WIDTH flops in total.
- Reset:
  - RESET_N low clears every entry to 0 immediately, without waiting for a clock edge.
  - As a result OUT = 0 and TQ = 0 while reset is held.
- Functional write (TC = 0):
  - On each rising CLK edge, every entry i with EN_IN[i] = 1 loads IN.
  - Entries with EN_IN[i] = 0 hold their value.
  - Several EN_IN bits may be set at once; every enabled entry loads the same IN.
- Read:
  - OUT is the bitwise OR of R[i] over all i with EN_OUT[i] = 1.
  - EN_OUT = 0 gives OUT = 0.
  - Correct one-hot use gives a plain mux.
  - OUT has no storage and no enable flop.
- Scan shift (TC = 1):
  - EN_IN is ignored. Every flop shifts one position per rising edge.
  - Chain order: TD -> R[0][0] -> R[0][1] -> ... -> R[0][WIDTH-1] -> R[1][0] -> ... -> R[DEPTH-1][WIDTH-1] -> TQ.
- TQ is always R[DEPTH-1][WIDTH-1], in both modes.
- OUT keeps following EN_OUT during scan, so it reflects the contents as they shift.
- Simultaneous events:
  - Reset overrides both write and shift.
  - TC = 1 overrides EN_IN.
  - A read of an entry being written returns the old value until the clock edge, and the new value after it.

## Timing
- Write latency: 1 CLK edge from EN_IN/IN being sampled to R updating.
- Read latency: 0 cycles. OUT is combinational from R and EN_OUT; the path is a DEPTH-input AND-OR per bit.
- Scan: a bit presented on TD appears on TQ after DEPTH*WIDTH rising edges (64 with defaults).
- Reset assertion is asynchronous.
- Reset release: the first write or shift takes effect on the first rising edge with RESET_N high.
- Mid-operation reset: if RESET_N drops during a scan shift or a write, all entries are 0 at once and the partial shift is discarded.
- TC is sampled at each edge, so mode can change on any cycle.
- No handshake and no busy state.

## Test plan
- Reset: load non-zero data, pulse RESET_N low with no clock edge.
  - OUT = 8'h00 for every one-hot EN_OUT value, and TQ = 0.
- Write/read:
  - Write 8'hA5 with EN_IN = 8'h08, then 8'h3C with EN_IN = 8'h80.
  - EN_OUT = 8'h08 -> OUT = 8'hA5; EN_OUT = 8'h80 -> OUT = 8'h3C; EN_OUT = 8'h01 -> OUT = 8'h00.
- Multi-write and OR read:
  - Write 8'hF0 with EN_IN = 8'h03 -> entries 0 and 1 both equal F0.
  - Write 8'h0F to entry 2. EN_OUT = 8'h06 -> OUT = 8'hFF; EN_OUT = 8'h00 -> OUT = 8'h00.
- Hold:
  - With EN_IN = 0 for 10 cycles while IN toggles, all entries stay unchanged.
  - With OUT selecting an entry, its value changes only on the edge where that entry's EN_IN bit is 1.
- Scan:
  - TC = 1, shift in a 64-bit pattern, TC = 0.
  - Read each entry and check the placement: pattern bit 63 ends in R[0][0], pattern bit 0 ends in R[7][7].
  - Shifting 64 more cycles with TD = 0 returns the pattern on TQ in order, first bit first.
  - EN_IN = 8'hFF during shift has no effect.
- Reset mid-scan: assert RESET_N after 20 shift cycles.
  - All entries = 0. Resuming the shift delivers TD to TQ after a full 64 further edges.
